// File: rtl/measurement_sequencer_if.sv
// Bundle between the SPI command decoder / readout side and the acquisition sequencer.
// The master side issues commands and takes results; the slave side is the sequencer.
interface measurement_sequencer_if #(
    parameter int IDX_W = 16
);
    logic             cmd_valid;
    logic [7:0]       command;
    logic [IDX_W-1:0] num_patterns;
    logic             result_ready;

    logic             pattern_trig;
    logic             clear_count;
    logic             start_count;
    logic             latch_count;
    logic             result_valid;
    logic [IDX_W-1:0] pattern_idx;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, command, num_patterns, result_ready,
        input  pattern_trig, clear_count, start_count, latch_count,
        input  result_valid, pattern_idx, busy, done
    );

    modport slave (
        input  cmd_valid, command, num_patterns, result_ready,
        output pattern_trig, clear_count, start_count, latch_count,
        output result_valid, pattern_idx, busy, done
    );
endinterface

// File: rtl/measurement_sequencer.sv
// Single-pixel-imaging acquisition sequencer: per pattern trigger DMD, settle, clear the
// photon counter, gate counting, latch, then hold the result until the readout takes it.
module measurement_sequencer #(
    parameter int SETTLE_CYCLES = 100,
    parameter int GATE_CYCLES   = 1000,
    parameter int IDX_W         = 16
) (
    input  logic clk,
    input  logic rst,
    measurement_sequencer_if.slave bus
);
    localparam int MAX_CYCLES = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] SETTLE_LOAD =
        TIMER_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TIMER_W-1:0] GATE_LOAD = TIMER_W'(GATE_CYCLES - 1);

    localparam logic [7:0] CMD_STOP  = 8'h00;
    localparam logic [7:0] CMD_START = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_SETTLE,
        ST_CLEAR,
        ST_GATE,
        ST_LATCH,
        ST_WAIT_RD
    } state_t;

    state_t             state_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic [IDX_W-1:0]   num_reg;
    logic [IDX_W-1:0]   pattern_idx_reg;
    logic               pattern_trig_reg;
    logic               clear_count_reg;
    logic               start_count_reg;
    logic               latch_count_reg;
    logic               result_valid_reg;
    logic               busy_reg;
    logic               done_reg;

    logic abort_cmd;
    logic start_cmd;
    logic last_pattern;

    assign abort_cmd    = bus.cmd_valid && (bus.command == CMD_STOP);
    assign start_cmd    = bus.cmd_valid && (bus.command == CMD_START) && (bus.num_patterns != '0);
    assign last_pattern = (pattern_idx_reg == num_reg - IDX_W'(1));

    // Abort is handled exactly like reset so that no stray LATCH or DONE can follow it.
    always_ff @(posedge clk) begin
        if (rst || abort_cmd) begin
            state_reg        <= ST_IDLE;
            timer_reg        <= '0;
            num_reg          <= '0;
            pattern_idx_reg  <= '0;
            pattern_trig_reg <= 1'b0;
            clear_count_reg  <= 1'b0;
            start_count_reg  <= 1'b0;
            latch_count_reg  <= 1'b0;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            pattern_trig_reg <= 1'b0;
            clear_count_reg  <= 1'b0;
            latch_count_reg  <= 1'b0;
            done_reg         <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start_cmd) begin
                        state_reg        <= ST_TRIG;
                        num_reg          <= bus.num_patterns;
                        pattern_idx_reg  <= '0;
                        pattern_trig_reg <= 1'b1;
                        busy_reg         <= 1'b1;
                    end
                end

                ST_TRIG: begin
                    if (SETTLE_CYCLES == 0) begin
                        state_reg       <= ST_CLEAR;
                        clear_count_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_SETTLE;
                        timer_reg <= SETTLE_LOAD;
                    end
                end

                ST_SETTLE: begin
                    if (timer_reg == '0) begin
                        state_reg       <= ST_CLEAR;
                        clear_count_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg - TIMER_W'(1);
                    end
                end

                ST_CLEAR: begin
                    state_reg       <= ST_GATE;
                    start_count_reg <= 1'b1;
                    timer_reg       <= GATE_LOAD;
                end

                // Timer counts down to zero so the gate spans exactly GATE_CYCLES cycles.
                ST_GATE: begin
                    if (timer_reg == '0) begin
                        state_reg       <= ST_LATCH;
                        start_count_reg <= 1'b0;
                        latch_count_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg - TIMER_W'(1);
                    end
                end

                ST_LATCH: begin
                    state_reg        <= ST_WAIT_RD;
                    result_valid_reg <= 1'b1;
                end

                ST_WAIT_RD: begin
                    if (result_valid_reg && bus.result_ready) begin
                        result_valid_reg <= 1'b0;
                        if (last_pattern) begin
                            state_reg       <= ST_IDLE;
                            pattern_idx_reg <= '0;
                            busy_reg        <= 1'b0;
                            done_reg        <= 1'b1;
                        end else begin
                            state_reg        <= ST_TRIG;
                            pattern_idx_reg  <= pattern_idx_reg + IDX_W'(1);
                            pattern_trig_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg        <= ST_IDLE;
                    start_count_reg  <= 1'b0;
                    result_valid_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pattern_trig = pattern_trig_reg;
    assign bus.clear_count  = clear_count_reg;
    assign bus.start_count  = start_count_reg;
    assign bus.latch_count  = latch_count_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.pattern_idx  = pattern_idx_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
endmodule
